spram_arbiter: RTL and testbench

SPRAM_ARBITER -- requirements
Module: spram_arbiter

---
 rtl/spram_pkg.sv | 18 +
 rtl/rr_arb2.sv | 21 ++
 rtl/spram_arbiter.sv | 123 ++++++++++++
 tb/tb_spram_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/spram_pkg.sv
// Shared definitions for the single-port RAM arbiter: default geometry,
// FSM state encoding and the last-winner encoding.
package spram_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  // Last-winner pointer values; the reset value WIN_B hands the first tie to A.
  localparam logic WIN_A = 1'b0;
  localparam logic WIN_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request always wins, a tie goes to the
// requester that did not win most recently.
module rr_arb2
  import spram_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_win,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_win == WIN_B) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/spram_arbiter.sv
// Arbitrates two requesters onto one single-port RAM with round-robin ties,
// lock-based read-modify-write ownership and one-cycle read return.
module spram_arbiter
  import spram_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          we_a,
  input  logic          we_b,
  input  logic          lock_a,
  input  logic          lock_b,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_a,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          rvalid_a,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  input  logic [DW-1:0] ram_dout
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_last;
  logic [1:0]    w_rr_gnt;
  logic [1:0]    w_gnt;
  logic          r_vld_a_p1;
  logic          r_vld_b_p1;
  logic [DW-1:0] r_rdata_a;
  logic [DW-1:0] r_rdata_b;
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_data;

  rr_arb2 u_rr_arb2 (
    .req      ({req_b, req_a}),
    .last_win (r_last),
    .gnt      (w_rr_gnt)
  );

  always_comb begin
    w_gnt       = 2'b00;
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        w_gnt = w_rr_gnt;
        if (w_rr_gnt[0] && lock_a)      w_state_nxt = OWN_A;
        else if (w_rr_gnt[1] && lock_b) w_state_nxt = OWN_B;
      end
      // An owner that stops requesting, or finishes with lock low, releases.
      OWN_A: begin
        w_gnt = {1'b0, req_a};
        if (!req_a || !lock_a) w_state_nxt = IDLE;
      end
      OWN_B: begin
        w_gnt = {req_b, 1'b0};
        if (!req_b || !lock_b) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (rst) w_gnt = 2'b00;
  end

  assign gnt_a = w_gnt[0];
  assign gnt_b = w_gnt[1];

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = r_ram_addr;
    ram_data = r_ram_data;
    if (w_gnt[0]) begin
      ram_we   = we_a;
      ram_addr = addr_a;
      ram_data = wdata_a;
    end else if (w_gnt[1]) begin
      ram_we   = we_b;
      ram_addr = addr_b;
      ram_data = wdata_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Grant stage -> return stage: RAM output is valid the cycle after the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last     <= WIN_B;
      r_vld_a_p1 <= 1'b0;
      r_vld_b_p1 <= 1'b0;
      r_rdata_a  <= '0;
      r_rdata_b  <= '0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
    end else begin
      if (|w_gnt) r_last <= w_gnt[1] ? WIN_B : WIN_A;
      r_vld_a_p1 <= w_gnt[0] & ~we_a;
      r_vld_b_p1 <= w_gnt[1] & ~we_b;
      if (r_vld_a_p1) r_rdata_a <= ram_dout;
      if (r_vld_b_p1) r_rdata_b <= ram_dout;
      r_ram_addr <= ram_addr;
      r_ram_data <= ram_data;
    end
  end

  assign rvalid_a = r_vld_a_p1;
  assign rvalid_b = r_vld_b_p1;
  assign rdata_a  = r_vld_a_p1 ? ram_dout : r_rdata_a;
  assign rdata_b  = r_vld_b_p1 ? ram_dout : r_rdata_b;

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter with a behavioural single-port RAM
// (registered address, combinational array read).
module tb_spram_arbiter;

  localparam int DW = 8;
  localparam int AW = 6;

  logic          clk;
  logic          rst;
  logic          req_a, req_b, we_a, we_b, lock_a, lock_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_dout;

  int total = 0;
  int bad   = 0;

  spram_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .lock_a(lock_a), .lock_b(lock_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .ram_dout(ram_dout)
  );

  logic [DW-1:0] mem [64];
  logic [AW-1:0] ram_addr_q;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_addr_q <= ram_addr;
  end
  assign ram_dout = mem[ram_addr_q];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_a = 0; req_b = 0; we_a = 0; we_b = 0; lock_a = 0; lock_b = 0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
  endtask

  task automatic test_reset();
    req_a = 1; req_b = 1; we_a = 1; addr_a = 6'd7; wdata_a = 8'hFF;
    @(negedge clk);
    total++; if (gnt_a !== 1'b0) begin bad++; $display("FAIL reset_gnt_a got=%b req=0", gnt_a); end
    total++; if (gnt_b !== 1'b0) begin bad++; $display("FAIL reset_gnt_b got=%b req=0", gnt_b); end
    total++; if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b%b req=00", rvalid_a, rvalid_b); end
    total++; if (rdata_a !== 8'h00 || rdata_b !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h/%h req=00/00", rdata_a, rdata_b); end
    total++; if (ram_we !== 1'b0 || ram_addr !== 6'd0 || ram_data !== 8'h00) begin bad++; $display("FAIL reset_ram got=%b/%h/%h req=0/00/00", ram_we, ram_addr, ram_data); end
    next_cycle();
    idle_inputs();
    rst = 0;
  endtask

  task automatic test_contention();
    logic [3:0] exp_ga;
    logic [3:0] exp_va;
    exp_ga = 4'b0101;
    exp_va = 4'b1010;
    req_a = 1; req_b = 1; addr_a = 6'd1; addr_b = 6'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (gnt_a !== exp_ga[i] || gnt_b !== ~exp_ga[i]) begin bad++; $display("FAIL contention_gnt[%0d] got=%b%b req=%b%b", i, gnt_a, gnt_b, exp_ga[i], ~exp_ga[i]); end
      if (i > 0) begin
        total++; if (rvalid_a !== exp_va[i] || rvalid_b !== ~exp_va[i]) begin bad++; $display("FAIL contention_rvalid[%0d] got=%b%b req=%b%b", i, rvalid_a, rvalid_b, exp_va[i], ~exp_va[i]); end
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    total++; if (rvalid_b !== 1'b1 || rvalid_a !== 1'b0 || gnt_a !== 1'b0 || gnt_b !== 1'b0) begin bad++; $display("FAIL contention_tail got=%b%b%b%b req=0100", rvalid_a, rvalid_b, gnt_a, gnt_b); end
    next_cycle();
  endtask

  task automatic test_single_read();
    req_a = 1; we_a = 1; addr_a = 6'd5; wdata_a = 8'h3C;
    @(negedge clk);
    total++; if (gnt_a !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 6'd5 || ram_data !== 8'h3C) begin bad++; $display("FAIL single_write got=%b/%b/%h/%h req=1/1/05/3c", gnt_a, ram_we, ram_addr, ram_data); end
    next_cycle();
    we_a = 0; wdata_a = 8'h00;
    @(negedge clk);
    total++; if (gnt_a !== 1'b1 || ram_we !== 1'b0 || rvalid_a !== 1'b0) begin bad++; $display("FAIL single_read_gnt got=%b/%b/%b req=1/0/0", gnt_a, ram_we, rvalid_a); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    total++; if (rvalid_a !== 1'b1 || rdata_a !== 8'h3C) begin bad++; $display("FAIL single_read_data got=%b/%h req=1/3c", rvalid_a, rdata_a); end
    total++; if (ram_we !== 1'b0 || ram_addr !== 6'd5 || ram_data !== 8'h00) begin bad++; $display("FAIL single_ram_hold got=%b/%h/%h req=0/05/00", ram_we, ram_addr, ram_data); end
    next_cycle();
    @(negedge clk);
    total++; if (rvalid_a !== 1'b0 || rdata_a !== 8'h3C) begin bad++; $display("FAIL single_rdata_hold got=%b/%h req=0/3c", rvalid_a, rdata_a); end
    next_cycle();
  endtask

  task automatic test_lock();
    req_a = 1; we_a = 1; addr_a = 6'd9; wdata_a = 8'h11;
    next_cycle();
    we_a = 0; lock_a = 1;
    @(negedge clk);
    total++; if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin bad++; $display("FAIL lock_first got=%b%b req=10", gnt_a, gnt_b); end
    next_cycle();
    we_a = 1; lock_a = 0; wdata_a = 8'h12;
    req_b = 1; addr_b = 6'd9;
    @(negedge clk);
    total++; if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin bad++; $display("FAIL lock_hold_b got=%b%b req=10", gnt_a, gnt_b); end
    total++; if (rvalid_a !== 1'b1 || rdata_a !== 8'h11) begin bad++; $display("FAIL lock_read got=%b/%h req=1/11", rvalid_a, rdata_a); end
    next_cycle();
    req_a = 0; we_a = 0;
    @(negedge clk);
    total++; if (gnt_b !== 1'b1 || gnt_a !== 1'b0 || rvalid_a !== 1'b0) begin bad++; $display("FAIL lock_release got=%b%b%b req=010", gnt_a, gnt_b, rvalid_a); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    total++; if (rvalid_b !== 1'b1 || rdata_b !== 8'h12) begin bad++; $display("FAIL lock_ram_update got=%b/%h req=1/12", rvalid_b, rdata_b); end
    next_cycle();
  endtask

  task automatic test_lock_abandon();
    req_a = 1; lock_a = 1; addr_a = 6'd9;
    @(negedge clk);
    total++; if (gnt_a !== 1'b1) begin bad++; $display("FAIL abandon_lock_gnt got=%b req=1", gnt_a); end
    next_cycle();
    req_a = 0; lock_a = 0; req_b = 1; addr_b = 6'd5;
    @(negedge clk);
    total++; if (gnt_a !== 1'b0 || gnt_b !== 1'b0) begin bad++; $display("FAIL abandon_wait got=%b%b req=00", gnt_a, gnt_b); end
    next_cycle();
    @(negedge clk);
    total++; if (gnt_b !== 1'b1 || gnt_a !== 1'b0) begin bad++; $display("FAIL abandon_grant_b got=%b%b req=01", gnt_a, gnt_b); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    total++; if (rvalid_b !== 1'b1 || rdata_b !== 8'h3C) begin bad++; $display("FAIL abandon_read_b got=%b/%h req=1/3c", rvalid_b, rdata_b); end
    next_cycle();
  endtask

  task automatic test_async_reset();
    req_a = 1; lock_a = 1; addr_a = 6'd5;
    @(negedge clk);
    total++; if (gnt_a !== 1'b1) begin bad++; $display("FAIL areset_pre_gnt got=%b req=1", gnt_a); end
    next_cycle();
    #1;
    total++; if (rvalid_a !== 1'b1 || rdata_a !== 8'h3C) begin bad++; $display("FAIL areset_pre_rvalid got=%b/%h req=1/3c", rvalid_a, rdata_a); end
    rst = 1;
    #1;
    total++; if (rvalid_a !== 1'b0 || rdata_a !== 8'h00 || gnt_a !== 1'b0) begin bad++; $display("FAIL areset_immediate got=%b/%h/%b req=0/00/0", rvalid_a, rdata_a, gnt_a); end
    total++; if (ram_addr !== 6'd0 || ram_we !== 1'b0) begin bad++; $display("FAIL areset_ram got=%h/%b req=00/0", ram_addr, ram_we); end
    idle_inputs();
    next_cycle();
    rst = 0;
    @(negedge clk);
    total++; if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin bad++; $display("FAIL areset_after got=%b%b req=00", rvalid_a, rvalid_b); end
    next_cycle();
    req_a = 1; req_b = 1; addr_a = 6'd5; addr_b = 6'd9;
    @(negedge clk);
    total++; if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin bad++; $display("FAIL areset_tie got=%b%b req=10", gnt_a, gnt_b); end
    next_cycle();
    @(negedge clk);
    total++; if (gnt_a !== 1'b0 || gnt_b !== 1'b1) begin bad++; $display("FAIL areset_idle got=%b%b req=01", gnt_a, gnt_b); end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    int rv_cnt;
    rv_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      req_a = 1; we_a = 1; addr_a = AW'(i); wdata_a = DW'(i * 5 + 3);
      @(negedge clk);
      total++; if (gnt_a !== 1'b1) begin bad++; $display("FAIL preload_gnt[%0d] got=%b req=1", i, gnt_a); end
      next_cycle();
    end
    idle_inputs();
    for (int i = 0; i < 64; i++) begin
      req_b = 1; addr_b = AW'(i);
      @(negedge clk);
      total++; if (gnt_b !== 1'b1) begin bad++; $display("FAIL b2b_gnt[%0d] got=%b req=1", i, gnt_b); end
      if (i > 0) begin
        if (rvalid_b === 1'b1) rv_cnt++;
        total++; if (rvalid_b !== 1'b1 || rdata_b !== DW'((i - 1) * 5 + 3)) begin bad++; $display("FAIL b2b_data[%0d] got=%b/%h req=1/%h", i - 1, rvalid_b, rdata_b, DW'((i - 1) * 5 + 3)); end
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    if (rvalid_b === 1'b1) rv_cnt++;
    total++; if (rvalid_b !== 1'b1 || rdata_b !== DW'(63 * 5 + 3)) begin bad++; $display("FAIL b2b_data[63] got=%b/%h req=1/%h", rvalid_b, rdata_b, DW'(63 * 5 + 3)); end
    total++; if (rv_cnt !== 64) begin bad++; $display("FAIL b2b_count got=%0d req=64", rv_cnt); end
    next_cycle();
    @(negedge clk);
    total++; if (rvalid_b !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b req=0", rvalid_b); end
    next_cycle();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    next_cycle();
    test_reset();
    test_contention();
    test_single_read();
    test_lock();
    test_lock_abandon();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
